// File: rtl/vga_vram_responder.sv
// VRAM memory-side responder: in-order request queue, fixed-latency SRAM issue port,
// and a credit-limited read return FIFO back to the VGA VRAM controller.
module vga_vram_responder #(
    parameter int P_QDEPTH     = 4,
    parameter int P_RDEPTH     = 4,
    parameter int P_RD_LATENCY = 2
) (
    input  logic        iCLOCK,
    input  logic        inRESET,
    input  logic        iRESET_SYNC,
    input  logic        iMEM_VALID,
    input  logic [1:0]  iMEM_BYTEENA,
    input  logic        iMEM_RW,
    input  logic [31:0] iMEM_ADDR,
    input  logic [15:0] iMEM_DATA,
    output logic        oMEM_BUSY,
    output logic        oMEM_VALID,
    output logic [15:0] oMEM_DATA,
    input  logic        iMEM_BUSY,
    output logic        oRAM_CS,
    output logic        oRAM_WE,
    output logic [1:0]  oRAM_BE,
    output logic [19:0] oRAM_ADDR,
    output logic [15:0] oRAM_WDATA,
    input  logic [15:0] iRAM_RDATA
);

    localparam int QAW = $clog2(P_QDEPTH);
    localparam int RAW = $clog2(P_RDEPTH);
    localparam logic [QAW:0]   L_QDEPTH = (QAW+1)'(P_QDEPTH);
    localparam logic [RAW+1:0] L_RDEPTH = (RAW+2)'(P_RDEPTH);

    typedef struct packed {
        logic        rw;
        logic [1:0]  be;
        logic [19:0] addr;
        logic [15:0] data;
    } req_t;

    logic rst;
    assign rst = !inRESET || iRESET_SYNC;

    logic unused_addr;
    assign unused_addr = ^iMEM_ADDR[31:20];

    // Request queue
    req_t             rq_mem [P_QDEPTH];
    logic [QAW-1:0]   rq_wptr_q, rq_wptr_d;
    logic [QAW-1:0]   rq_rptr_q, rq_rptr_d;
    logic [QAW:0]     rq_cnt_q,  rq_cnt_d;

    // Return FIFO
    logic [15:0]      rt_mem [P_RDEPTH];
    logic [RAW-1:0]   rt_wptr_q, rt_wptr_d;
    logic [RAW-1:0]   rt_rptr_q, rt_rptr_d;
    logic [RAW:0]     rt_cnt_q,  rt_cnt_d;
    logic [RAW:0]     inflight_q, inflight_d;

    logic [P_RD_LATENCY-1:0] tag_q, tag_d;

    logic        cs_q, cs_d;
    logic        we_q, we_d;
    logic [1:0]  be_q, be_d;
    logic [19:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;

    req_t in_req, cand;
    logic mem_push, q_empty, cand_valid, credit_ok, issue, rd_issue;
    logic rq_push, rq_pop, rt_push, rt_pop;

    // The tag enters the shift register the cycle after the read strobe, so its exit
    // lines up with iRAM_RDATA becoming valid P_RD_LATENCY cycles after oRAM_CS.
    genvar gi;
    generate
        for (gi = 0; gi < P_RD_LATENCY; gi++) begin : g_tag
            if (gi == 0) begin : g_head
                assign tag_d[gi] = cs_q && !we_q;
            end else begin : g_body
                assign tag_d[gi] = tag_q[gi-1];
            end
        end
    endgenerate

    always_comb begin
        in_req.rw   = iMEM_RW;
        in_req.be   = (iMEM_BYTEENA == 2'b00) ? 2'b11 : iMEM_BYTEENA;
        in_req.addr = iMEM_ADDR[19:0];
        in_req.data = iMEM_DATA;

        mem_push   = iMEM_VALID && !oMEM_BUSY;
        q_empty    = (rq_cnt_q == '0);
        // An empty queue lets a fresh request go straight to the RAM port.
        cand       = q_empty ? in_req : rq_mem[rq_rptr_q];
        cand_valid = !q_empty || mem_push;
        credit_ok  = ({1'b0, inflight_q} + {1'b0, rt_cnt_q}) < L_RDEPTH;
        issue      = cand_valid && (cand.rw || credit_ok);
        rd_issue   = issue && !cand.rw;
        rq_push    = mem_push && !(q_empty && issue);
        rq_pop     = issue && !q_empty;

        rq_wptr_d = rq_push ? rq_wptr_q + 1'b1 : rq_wptr_q;
        rq_rptr_d = rq_pop  ? rq_rptr_q + 1'b1 : rq_rptr_q;
        rq_cnt_d  = rq_cnt_q + (QAW+1)'(rq_push) - (QAW+1)'(rq_pop);

        rt_push   = tag_q[P_RD_LATENCY-1];
        rt_pop    = (rt_cnt_q != '0) && !iMEM_BUSY;
        rt_wptr_d = rt_push ? rt_wptr_q + 1'b1 : rt_wptr_q;
        rt_rptr_d = rt_pop  ? rt_rptr_q + 1'b1 : rt_rptr_q;
        rt_cnt_d  = rt_cnt_q + (RAW+1)'(rt_push) - (RAW+1)'(rt_pop);
        inflight_d = inflight_q + (RAW+1)'(rd_issue) - (RAW+1)'(rt_push);

        cs_d    = issue;
        we_d    = issue && cand.rw;
        be_d    = issue ? cand.be   : be_q;
        addr_d  = issue ? cand.addr : addr_q;
        wdata_d = issue ? cand.data : wdata_q;
    end

    always_ff @(posedge iCLOCK) begin
        if (rst) begin
            rq_wptr_q  <= '0;
            rq_rptr_q  <= '0;
            rq_cnt_q   <= '0;
            rt_wptr_q  <= '0;
            rt_rptr_q  <= '0;
            rt_cnt_q   <= '0;
            inflight_q <= '0;
            tag_q      <= '0;
            cs_q       <= 1'b0;
            we_q       <= 1'b0;
            be_q       <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
        end else begin
            rq_wptr_q  <= rq_wptr_d;
            rq_rptr_q  <= rq_rptr_d;
            rq_cnt_q   <= rq_cnt_d;
            rt_wptr_q  <= rt_wptr_d;
            rt_rptr_q  <= rt_rptr_d;
            rt_cnt_q   <= rt_cnt_d;
            inflight_q <= inflight_d;
            tag_q      <= tag_d;
            cs_q       <= cs_d;
            we_q       <= we_d;
            be_q       <= be_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
        end
    end

    always_ff @(posedge iCLOCK) begin
        if (rq_push) begin
            rq_mem[rq_wptr_q] <= in_req;
        end
        if (rt_push) begin
            rt_mem[rt_wptr_q] <= iRAM_RDATA;
        end
    end

    assign oMEM_BUSY  = (rq_cnt_q == L_QDEPTH);
    assign oMEM_VALID = (rt_cnt_q != '0);
    assign oMEM_DATA  = oMEM_VALID ? rt_mem[rt_rptr_q] : 16'h0000;
    assign oRAM_CS    = cs_q;
    assign oRAM_WE    = we_q;
    assign oRAM_BE    = be_q;
    assign oRAM_ADDR  = addr_q;
    assign oRAM_WDATA = wdata_q;

endmodule

// File: tb/tb_vga_vram_responder.sv
// Directed bench for vga_vram_responder with a byte-enable aware 2-cycle SRAM model.
module tb_vga_vram_responder;

    localparam int L = 2;

    logic        iCLOCK = 1'b0;
    logic        inRESET = 1'b0;
    logic        iRESET_SYNC = 1'b0;
    logic        iMEM_VALID = 1'b0;
    logic [1:0]  iMEM_BYTEENA = 2'b00;
    logic        iMEM_RW = 1'b0;
    logic [31:0] iMEM_ADDR = 32'h0;
    logic [15:0] iMEM_DATA = 16'h0;
    logic        iMEM_BUSY = 1'b0;
    logic        oMEM_BUSY, oMEM_VALID, oRAM_CS, oRAM_WE;
    logic [15:0] oMEM_DATA, oRAM_WDATA, iRAM_RDATA;
    logic [1:0]  oRAM_BE;
    logic [19:0] oRAM_ADDR;

    int n_vec = 0;
    int n_err = 0;

    vga_vram_responder #(.P_QDEPTH(4), .P_RDEPTH(4), .P_RD_LATENCY(L)) dut (
        .iCLOCK(iCLOCK), .inRESET(inRESET), .iRESET_SYNC(iRESET_SYNC),
        .iMEM_VALID(iMEM_VALID), .iMEM_BYTEENA(iMEM_BYTEENA), .iMEM_RW(iMEM_RW),
        .iMEM_ADDR(iMEM_ADDR), .iMEM_DATA(iMEM_DATA), .oMEM_BUSY(oMEM_BUSY),
        .oMEM_VALID(oMEM_VALID), .oMEM_DATA(oMEM_DATA), .iMEM_BUSY(iMEM_BUSY),
        .oRAM_CS(oRAM_CS), .oRAM_WE(oRAM_WE), .oRAM_BE(oRAM_BE),
        .oRAM_ADDR(oRAM_ADDR), .oRAM_WDATA(oRAM_WDATA), .iRAM_RDATA(iRAM_RDATA)
    );

    always #5 iCLOCK = ~iCLOCK;

    // SRAM model: writes honour byte enables, read data appears L cycles after CS.
    logic [15:0] ram  [1024];
    logic [15:0] pipe [L];
    always @(posedge iCLOCK) begin
        if (oRAM_CS && oRAM_WE) begin
            ram[oRAM_ADDR[9:0]] <= {oRAM_BE[1] ? oRAM_WDATA[15:8] : ram[oRAM_ADDR[9:0]][15:8],
                                    oRAM_BE[0] ? oRAM_WDATA[7:0]  : ram[oRAM_ADDR[9:0]][7:0]};
        end
        pipe[0] <= (oRAM_CS && !oRAM_WE) ? ram[oRAM_ADDR[9:0]] : 16'hDEAD;
        for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
    end
    assign iRAM_RDATA = pipe[L-1];

    logic [15:0] ret_q[$];
    logic [35:0] wr_log[$];
    int rd_issues = 0;
    always @(posedge iCLOCK) begin
        if (oMEM_VALID && !iMEM_BUSY) ret_q.push_back(oMEM_DATA);
        if (oRAM_CS && oRAM_WE) wr_log.push_back({oRAM_ADDR, oRAM_WDATA});
        if (oRAM_CS && !oRAM_WE) rd_issues <= rd_issues + 1;
    end

    task automatic check(input string tag, input logic [35:0] obs, input logic [35:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge iCLOCK);
        #1;
    endtask

    task automatic send(input logic rw, input logic [1:0] be, input logic [31:0] addr,
                        input logic [15:0] data);
        logic acc;
        iMEM_VALID = 1'b1; iMEM_RW = rw; iMEM_BYTEENA = be;
        iMEM_ADDR = addr;  iMEM_DATA = data;
        acc = 1'b0;
        for (int k = 0; k < 50 && !acc; k++) begin
            acc = !oMEM_BUSY;
            tick();
        end
        check("accept", {35'h0, acc}, 36'h1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},  {35'h0, oMEM_BUSY},  36'h0);
        check({tag, "_valid"}, {35'h0, oMEM_VALID}, 36'h0);
        check({tag, "_data"},  {20'h0, oMEM_DATA},  36'h0);
        check({tag, "_cs"},    {35'h0, oRAM_CS},    36'h0);
        check({tag, "_we"},    {35'h0, oRAM_WE},    36'h0);
        check({tag, "_be"},    {34'h0, oRAM_BE},    36'h0);
        check({tag, "_addr"},  {16'h0, oRAM_ADDR},  36'h0);
        check({tag, "_wdata"}, {20'h0, oRAM_WDATA}, 36'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int base, wbase, rd0, cyc;

        // Reset state
        repeat (3) tick();
        check_all_zero("reset");
        inRESET = 1'b1;
        tick();

        // Write then read same address, nominal latency
        send(1'b1, 2'b00, 32'h0000_0010, 16'hA5A5);
        check("wr_cs",    {35'h0, oRAM_CS},    36'h1);
        check("wr_we",    {35'h0, oRAM_WE},    36'h1);
        check("wr_be",    {34'h0, oRAM_BE},    36'h3);
        check("wr_addr",  {16'h0, oRAM_ADDR},  36'h10);
        check("wr_wdata", {20'h0, oRAM_WDATA}, 36'hA5A5);
        send(1'b0, 2'b00, 32'hFFF0_0010, 16'h0000);
        iMEM_VALID = 1'b0;
        check("rd_cs", {35'h0, oRAM_CS}, 36'h1);
        check("rd_we", {35'h0, oRAM_WE}, 36'h0);
        tick();
        check("lat_c2_valid", {35'h0, oMEM_VALID}, 36'h0);
        tick();
        check("lat_c3_valid", {35'h0, oMEM_VALID}, 36'h0);
        tick();
        check("lat_c4_valid", {35'h0, oMEM_VALID}, 36'h1);
        check("lat_c4_data",  {20'h0, oMEM_DATA},  36'hA5A5);
        tick();
        check("lat_popped", {35'h0, oMEM_VALID}, 36'h0);

        // Partial byte-enable write
        send(1'b1, 2'b11, 32'h20, 16'hFFFF);
        send(1'b1, 2'b01, 32'h20, 16'h1234);
        check("be01_be", {34'h0, oRAM_BE}, 36'h1);
        send(1'b0, 2'b00, 32'h20, 16'h0000);
        iMEM_VALID = 1'b0;
        cyc = 0;
        while (!oMEM_VALID && cyc < 10) begin tick(); cyc++; end
        check("be01_data", {20'h0, oMEM_DATA}, 36'hFF34);
        tick();

        // Back-to-back reads with the return path stalled
        for (int i = 0; i < 8; i++) send(1'b1, 2'b00, 32'h100 + i, 16'h1000 + 16'(i));
        iMEM_VALID = 1'b0;
        repeat (2) tick();
        iMEM_BUSY = 1'b1;
        rd0  = rd_issues;
        base = ret_q.size();
        for (int i = 0; i < 8; i++) send(1'b0, 2'b00, 32'h100 + i, 16'h0000);
        iMEM_VALID = 1'b0;
        repeat (6) tick();
        check("stall_rd_issued", 36'(rd_issues - rd0), 36'd4);
        check("stall_valid",     {35'h0, oMEM_VALID}, 36'h1);
        check("stall_data",      {20'h0, oMEM_DATA},  36'h1000);
        check("stall_qfull",     {35'h0, oMEM_BUSY},  36'h1);
        repeat (3) tick();
        check("stall_data_hold", {20'h0, oMEM_DATA},  36'h1000);
        iMEM_BUSY = 1'b0;
        for (int k = 0; k < 40 && (ret_q.size() - base) < 8; k++) tick();
        check("stall_ret_count", 36'(ret_q.size() - base), 36'd8);
        for (int i = 0; i < 8 && base + i < ret_q.size(); i++)
            check($sformatf("stall_ret%0d", i), {20'h0, ret_q[base+i]}, 36'h1000 + 36'(i));
        check("stall_rd_total", 36'(rd_issues - rd0), 36'd8);

        // Writes held behind a credit-blocked read
        iMEM_BUSY = 1'b1;
        base  = ret_q.size();
        wbase = wr_log.size();
        for (int i = 0; i < 5; i++) send(1'b0, 2'b00, 32'h100 + i, 16'h0000);
        for (int i = 0; i < 3; i++) send(1'b1, 2'b00, 32'h200 + i, 16'h2000 + 16'(i));
        check("blk_busy_at4", {35'h0, oMEM_BUSY}, 36'h1);
        iMEM_VALID = 1'b1; iMEM_RW = 1'b1; iMEM_ADDR = 32'h203; iMEM_DATA = 16'h2003;
        repeat (3) tick();
        check("blk_busy_hold", {35'h0, oMEM_BUSY}, 36'h1);
        check("blk_no_writes", 36'(wr_log.size() - wbase), 36'd0);
        iMEM_BUSY = 1'b0;
        for (int i = 3; i < 6; i++) send(1'b1, 2'b00, 32'h200 + i, 16'h2000 + 16'(i));
        iMEM_VALID = 1'b0;
        for (int k = 0; k < 40 && ((wr_log.size() - wbase) < 6 || (ret_q.size() - base) < 5); k++)
            tick();
        repeat (3) tick();
        check("blk_wr_count", 36'(wr_log.size() - wbase), 36'd6);
        for (int i = 0; i < 6 && wbase + i < wr_log.size(); i++)
            check($sformatf("blk_wr%0d", i), wr_log[wbase+i],
                  {20'h200 + 20'(i), 16'h2000 + 16'(i)});
        check("blk_ret_count", 36'(ret_q.size() - base), 36'd5);
        if (ret_q.size() >= base + 5) begin
            check("blk_ret0", {20'h0, ret_q[base]},   36'h1000);
            check("blk_ret4", {20'h0, ret_q[base+4]}, 36'h1004);
        end

        // Hard reset with reads in flight
        base = ret_q.size();
        send(1'b0, 2'b00, 32'h100, 16'h0);
        send(1'b0, 2'b00, 32'h101, 16'h0);
        iMEM_VALID = 1'b0;
        inRESET = 1'b0;
        tick();
        inRESET = 1'b1;
        check_all_zero("hrst");
        repeat (8) tick();
        check("hrst_dropped", 36'(ret_q.size() - base), 36'd0);
        check("hrst_valid",   {35'h0, oMEM_VALID}, 36'h0);

        // Soft reset with the queue full
        iMEM_BUSY = 1'b1;
        for (int i = 0; i < 8; i++) send(1'b0, 2'b00, 32'h100 + i, 16'h0);
        iMEM_VALID = 1'b0;
        tick();
        check("srst_pre_busy", {35'h0, oMEM_BUSY}, 36'h1);
        iRESET_SYNC = 1'b1;
        tick();
        iRESET_SYNC = 1'b0;
        check("srst_busy",  {35'h0, oMEM_BUSY},  36'h0);
        check("srst_valid", {35'h0, oMEM_VALID}, 36'h0);
        check("srst_cs",    {35'h0, oRAM_CS},    36'h0);
        iMEM_BUSY = 1'b0;
        send(1'b0, 2'b00, 32'h105, 16'h0);
        iMEM_VALID = 1'b0;
        check("srst_c1_cs",   {35'h0, oRAM_CS},   36'h1);
        check("srst_c1_addr", {16'h0, oRAM_ADDR}, 36'h105);
        repeat (2) tick();
        check("srst_c3_valid", {35'h0, oMEM_VALID}, 36'h0);
        tick();
        check("srst_c4_valid", {35'h0, oMEM_VALID}, 36'h1);
        check("srst_c4_data",  {20'h0, oMEM_DATA},  36'h1005);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/vga_vram_responder.md
Name: vga_vram_responder

Overview:
- Memory-side responder for the VGA VRAM request interface. It accepts valid/busy-handshaked read and write requests from the VRAM controller and queues them in order.
- Requests are issued one per cycle to a synchronous SRAM-style VRAM port with fixed read latency.
- Read data returns to the requester in request order through a credit-limited return FIFO.
- Sits between vga_vram_control and the VRAM backing store.

Parameters:
- P_QDEPTH, 4, request queue entries (power of 2, ≥2)
- P_RDEPTH, 4, return FIFO entries (power of 2, ≥2)
- P_RD_LATENCY, 2, RAM read latency in cycles from oRAM_CS to iRAM_RDATA valid (≥1)

Ports:
- iCLOCK  in  1  system clock
- inRESET  in  1  synchronous active-low reset
- iRESET_SYNC  in  1  synchronous soft reset, active-high; same effect as reset
- iMEM_VALID  in  1  request valid
- iMEM_BYTEENA  in  2  byte enables; 2'b00 means both bytes
- iMEM_RW  in  1  0 = read, 1 = write
- iMEM_ADDR  in  32  word address; bits [19:0] used, upper bits ignored
- iMEM_DATA  in  16  write data
- oMEM_BUSY  out  1  request backpressure
- oMEM_VALID  out  1  read data valid
- oMEM_DATA  out  16  read data
- iMEM_BUSY  in  1  requester stalls read return
- oRAM_CS  out  1  RAM access strobe
- oRAM_WE  out  1  RAM write enable
- oRAM_BE  out  2  RAM byte enables
- oRAM_ADDR  out  20  RAM address
- oRAM_WDATA  out  16  RAM write data
- iRAM_RDATA  in  16  RAM read data

Behaviour:
- Single clock domain (iCLOCK). Reset is synchronous and active-low on inRESET. iRESET_SYNC has identical effect.
- Reset/soft-reset effect:
  - Both FIFOs are emptied and the read-latency tag pipeline is cleared; in-flight reads are dropped.
  - Outputs after reset: oMEM_BUSY=0, oMEM_VALID=0, oMEM_DATA=0, oRAM_CS=0, oRAM_WE=0, oRAM_BE=0, oRAM_ADDR=0, oRAM_WDATA=0.
- Request acceptance:
  - A transfer occurs in any cycle with iMEM_VALID && !oMEM_BUSY. {rw, be, addr[19:0], data} is pushed to the request queue.
  - While busy, the requester holds its request stable; it is accepted on the first non-busy cycle and never duplicated.
- oMEM_BUSY = queue count == P_QDEPTH. It is derived from registers only, with no input-to-output combinational path.
- Byte-enable mapping: be 2'b00 maps to oRAM_BE 2'b11; any other value passes through unchanged.
- Issue stage (registered outputs):
  - Each cycle, if the queue is non-empty and the head entry is issuable, pop it and drive oRAM_CS=1, oRAM_WE=rw, BE/ADDR/WDATA next cycle. Otherwise drive oRAM_CS=0 and oRAM_WE=0.
  - A write head is always issuable.
  - A read head is issuable only if (reads in flight + return FIFO count) < P_RDEPTH.
  - The queue is strictly in-order: a blocked read blocks following writes.
  - Address/data outputs are don't-care when CS=0; they hold their last value.
- Read return:
  - A tag shift register of length P_RD_LATENCY marks read issues.
  - When a tag exits, iRAM_RDATA is pushed into the return FIFO in that same cycle.
  - oMEM_VALID = return FIFO non-empty. oMEM_DATA = FIFO head.
  - Pop on oMEM_VALID && !iMEM_BUSY. Data is held stable while iMEM_BUSY.
- Latency with an empty pipeline (request sampled in cycle 0):
  - oRAM_CS in cycle 1.
  - RAM data in cycle 1+P_RD_LATENCY.
  - oMEM_VALID in cycle 2+P_RD_LATENCY (cycle 4 with defaults).
  - Throughput is one request per cycle.
- Simultaneous events:
  - Push and pop of either FIFO in the same cycle leaves the count unchanged.
  - Credit accounting counts a same-cycle return pop as freeing a slot for the next cycle only.
  - Pointers wrap modulo depth.
- Ordering: read-after-write to the same address returns the written data, because RAM accesses are issued in order.

Test Plan:
- Write (addr 0x00010, data 0xA5A5, be 00) followed by a read of 0x00010 in consecutive cycles → oRAM_BE=11 on the write; oMEM_VALID with data 0xA5A5 exactly 4 cycles after the read was sampled.
- iMEM_VALID held high for 6 writes with the RAM side stalled by leading blocked reads → oMEM_BUSY asserts at queue count 4; no request is lost or duplicated; all 6 appear on the RAM port in order.
- 8 back-to-back reads with iMEM_BUSY=1 → at most 4 oRAM_CS reads issue; oMEM_VALID stays high with the first data stable. Release iMEM_BUSY → all 8 data words return in address order.
- be=01 write of 0x1234 over 0xFFFF, then a read → oRAM_BE=01 on the write; the read returns 0xFF34 (RAM model honours BE).
- Reads in flight when inRESET=0 for one cycle → next cycle all outputs are 0; the dropped data never produces oMEM_VALID.
- iRESET_SYNC pulse with the queue full → oMEM_BUSY=0 the next cycle; the next request is serviced with the nominal 4-cycle read latency.
